// File: rtl/pc_unit_if.sv
// Bus between the control/ALU side and the PC unit: redirect requests in, fetch address and status out.
interface pc_unit_if #(
    parameter int unsigned AW        = 32,
    parameter int unsigned RAS_DEPTH = 4
);
    localparam int unsigned CW = $clog2(RAS_DEPTH) + 1;

    logic          stall;
    logic          halt;
    logic          resume;
    logic          branch_taken;
    logic [15:0]   imm16;
    logic          jump;
    logic [25:0]   idx26;
    logic          link;
    logic          jr;
    logic          ret;
    logic [AW-1:0] jr_target;
    logic          exc;

    logic [AW-1:0] pc;
    logic [AW-1:0] pc_plus;
    logic          pc_valid;
    logic [AW-1:0] epc;
    logic          misalign_exc;
    logic [CW-1:0] ras_count;

    modport master (
        output stall, halt, resume, branch_taken, imm16, jump, idx26,
               link, jr, ret, jr_target, exc,
        input  pc, pc_plus, pc_valid, epc, misalign_exc, ras_count
    );

    modport slave (
        input  stall, halt, resume, branch_taken, imm16, jump, idx26,
               link, jr, ret, jr_target, exc,
        output pc, pc_plus, pc_valid, epc, misalign_exc, ras_count
    );
endinterface

// File: rtl/pc_unit.sv
// Program counter with next-PC selection, boot/halt control, EPC capture,
// misaligned register-jump trapping and a circular return-address stack.
module pc_unit #(
    parameter int unsigned    AW        = 32,
    parameter logic [AW-1:0]  RESET_VEC = '0,
    parameter logic [31:0]    EXC_VEC   = 32'h0000_0380,
    parameter int unsigned    INC       = 4,
    parameter int unsigned    RAS_DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    pc_unit_if.slave bus
);
    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [AW-1:0] EXC_PC   = AW'(EXC_VEC);
    localparam logic [AW-1:0] HI_MASK  = ~AW'(32'h0FFF_FFFF);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t        state;
    logic [AW-1:0] pc_q;
    logic [AW-1:0] epc_q;
    logic          valid_q;
    logic          mis_q;
    logic [CW-1:0] count_q;
    logic [PW-1:0] sp_q;
    logic [AW-1:0] ras_mem [RAS_DEPTH];

    logic [AW-1:0] pc_plus_c;
    logic [AW-1:0] ras_top_c;
    logic [AW-1:0] jr_tgt_c;
    logic [AW-1:0] jump_tgt_c;
    logic [AW-1:0] br_tgt_c;
    logic          run_go_c;
    logic          jr_bad_c;
    logic          pop_c;
    logic          push_c;

    // Candidate targets and RAS push/pop decisions for the current cycle.
    always_comb begin
        pc_plus_c  = pc_q + AW'(INC);
        ras_top_c  = ras_mem[sp_q - PW'(1)];
        jr_tgt_c   = (bus.ret && (count_q != '0)) ? ras_top_c : bus.jr_target;
        jump_tgt_c = (pc_plus_c & HI_MASK) | AW'({bus.idx26, 2'b00});
        br_tgt_c   = pc_plus_c + {{(AW-18){bus.imm16[15]}}, bus.imm16, 2'b00};
        run_go_c   = (state == S_RUN) && !bus.exc && !bus.halt && !bus.stall;
        jr_bad_c   = bus.jr && (jr_tgt_c[1:0] != 2'b00);
        pop_c      = run_go_c && bus.jr && !jr_bad_c && bus.ret && (count_q != '0);
        push_c     = run_go_c && bus.link &&
                     ((bus.jr && !jr_bad_c && !bus.ret) || (!bus.jr && bus.jump));
    end

    // State machine, PC/EPC update and RAS bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_BOOT;
            pc_q    <= RESET_VEC;
            epc_q   <= '0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            count_q <= '0;
            sp_q    <= '0;
        end else begin
            mis_q <= 1'b0;
            unique case (state)
                S_BOOT: begin
                    state   <= S_RUN;
                    valid_q <= 1'b1;
                end
                S_HALT: begin
                    if (bus.exc) begin
                        pc_q    <= EXC_PC;
                        epc_q   <= pc_q;
                        state   <= S_RUN;
                        valid_q <= 1'b1;
                    end else if (bus.resume) begin
                        state   <= S_RUN;
                        valid_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (bus.exc) begin
                        pc_q  <= EXC_PC;
                        epc_q <= pc_q;
                    end else if (bus.halt) begin
                        state   <= S_HALT;
                        valid_q <= 1'b0;
                    end else if (bus.stall) begin
                        pc_q <= pc_q;
                    end else if (jr_bad_c) begin
                        pc_q  <= EXC_PC;
                        epc_q <= pc_q;
                        mis_q <= 1'b1;
                    end else if (bus.jr) begin
                        pc_q <= jr_tgt_c;
                    end else if (bus.jump) begin
                        pc_q <= jump_tgt_c;
                    end else if (bus.branch_taken) begin
                        pc_q <= br_tgt_c;
                    end else begin
                        pc_q <= pc_plus_c;
                    end
                end
                default: begin
                    state   <= S_BOOT;
                    valid_q <= 1'b0;
                end
            endcase

            // Pointer always moves; count saturates so a full push drops the oldest entry.
            if (pop_c) begin
                sp_q    <= sp_q - PW'(1);
                count_q <= count_q - CW'(1);
            end else if (push_c) begin
                sp_q <= sp_q + PW'(1);
                if (count_q != CW'(RAS_DEPTH)) begin
                    count_q <= count_q + CW'(1);
                end
            end
        end
    end

    // RAS storage; contents are meaningless while count is zero, so no reset needed.
    always_ff @(posedge clk) begin
        if (push_c) begin
            ras_mem[sp_q] <= pc_plus_c;
        end
    end

    assign bus.pc           = pc_q;
    assign bus.pc_plus      = pc_plus_c;
    assign bus.pc_valid     = valid_q;
    assign bus.epc          = epc_q;
    assign bus.misalign_exc = mis_q;
    assign bus.ras_count    = count_q;
endmodule
